lua_mem_arbiter: RTL
====================

# lua_mem_arbiter

Shares the single Avalon-MM master port of `lua_cpu` between its memory requesters: the instruction fetch, PC load/store and the planned register spill/fill unit. It replaces the current OR-combining of requester buses with a registered one-hot grant. Transfers are serialized, and `waitrequest` is returned per requester, so requesters may issue concurrently.

## Interface
Parameters:
- `N_REQ`, default 3: number of requesters. Index 0 is instruction fetch, 1 is PC, 2 is register spill/fill.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_address`  in  `N_REQ*ADDR_W`  per-requester address. Requester i occupies slice `[i*ADDR_W +: ADDR_W]`.
- `req_writedata`  in  `N_REQ*DATA_W`  per-requester write data.
- `req_read`  in  `N_REQ`  per-requester read request.
- `req_write`  in  `N_REQ`  per-requester write request.
- `req_readdata`  out  `DATA_W`  broadcast of `m_readdata`.
- `req_waitrequest`  out  `N_REQ`  per-requester stall.
- `grant`  out  `N_REQ`  one-hot registered grant; 0 when idle.
- `busy`  out  1  high in the GRANT state.
- `m_address`  out  `ADDR_W`  master address.
- `m_writedata`  out  `DATA_W`  master write data.
- `m_read`  out  1  master read.
- `m_write`  out  1  master write.
- `m_readdata`  in  `DATA_W`  master read data.
- `m_waitrequest`  in  1  master stall.

## Operation
- Requester i is active when `req_read[i] | req_write[i]`.
- IDLE state:
  - Master outputs are all 0.
  - If any requester is active, the winner is selected. The grant is registered and the FSM moves to GRANT on the next edge.
- GRANT state:
  - The granted requester's address, writedata, read and write drive the master port.
  - If the granted requester has both read and write high, write wins and `m_read` is 0.
- Completion:
  - A transfer completes in the GRANT cycle in which (`m_read | m_write`) is high and `m_waitrequest` is 0.
  - At the next edge the FSM returns to IDLE, the grant clears and the arbitration pointer updates.
- Early drop: if the granted requester drops both read and write while in GRANT, the FSM returns to IDLE at the next edge. No master transfer is issued, and the pointer does not update.
- `req_waitrequest[i]` is 0 only when `grant[i]` is set and `m_waitrequest` is 0. It is 1 in every other case, including idle.
- `req_readdata` always equals `m_readdata`. It is valid for requester i only in its completion cycle.
- Requesters hold their request until they see `req_waitrequest` low. The existing `done`-gated requesters already meet this rule.

## Timing
- Reset values:
  - `grant` = 0, `busy` = 0, FSM = IDLE, arbitration pointer = 0.
  - `m_read`, `m_write`, `m_address` and `m_writedata` are all 0.
  - `req_waitrequest` is all 1s.
- Arbitration latency: a request first seen in IDLE in cycle t is forwarded to the master in cycle t+1.
  - With zero-wait memory, completion is at t+1.
  - With W wait cycles, completion is at t+1+W.
- There is always one IDLE cycle between consecutive grants, so the minimum back-to-back period is 2 cycles per transfer.
- Simultaneous requests in IDLE: exactly one winner is chosen; losers see `req_waitrequest` = 1 until they are granted.
- A new request arriving during GRANT waits for the next IDLE cycle.
- Reset asserted mid-transfer (asynchronous): all state and outputs take reset values immediately. `m_read` and `m_write` drop in the same cycle; the transfer is abandoned.

## Configuration
- `LUA_ARB_ROUND_ROBIN_EN` defined: round-robin selection.
  - The search starts at (index of last completed grant + 1) mod `N_REQ`.
  - The pointer updates only on completion.
- Not defined: fixed priority, with the lowest index winning. The pointer register is not built.

## Structure
- Shared package `lua_cpu_pkg`:
  - arbiter state encoding: `ARB_IDLE` = 0, `ARB_GRANT` = 1;
  - requester index constants `REQ_IR` = 0, `REQ_PC` = 1, `REQ_RF` = 2;
  - default `N_REQ`.
- Sub-module `lua_arb_select`: combinational one-hot winner selection from the active vector and pointer, plus an encoded winner index. It contains both the round-robin and fixed-priority paths, selected under the macro.

## Test plan
- Read, zero-wait: req0 read at address `0x0000_1000`, `m_readdata` = `0xDEADBEEF`.
  - One cycle later `grant` = `3'b001` and `m_address` = `0x1000`.
  - `req_waitrequest[0]` is low for exactly one cycle, with `req_readdata` = `0xDEADBEEF`.
- Write with waits: req1 writes `0x0000_0042` to `0x2014` while `m_waitrequest` is held high for 3 cycles.
  - `m_write` stays high for 4 cycles, then `grant` returns to 0.
- Contention: req0 read and req2 write asserted in the same cycle, both held across repeated transfers.
  - Without the macro: req0 is served first and every subsequent transfer is also req0.
  - With the macro: grants alternate 0, 2, 0, 2.
- Read and write both high: req2 asserts read and write together → `m_write` = 1, `m_read` = 0.
- Early drop: req1 drops its read in the GRANT cycle while `m_waitrequest` = 1.
  - The FSM returns to IDLE next cycle.
  - No completion occurs and the pointer is unchanged.
- Reset mid-transfer: assert `rst` during GRANT.
  - `m_read`, `grant` and `busy` go to 0 in the same cycle and `req_waitrequest` goes to all 1s.
  - After release, the first arbitration selects from pointer 0.

Source files
------------

// File: rtl/lua_cpu_pkg.sv
// rtl/lua_cpu_pkg.sv - shared lua_cpu constants: arbiter state encoding, requester indices.
package lua_cpu_pkg;

    localparam logic [0:0] ARB_IDLE  = 1'b0;
    localparam logic [0:0] ARB_GRANT = 1'b1;

    localparam int REQ_IR = 0;
    localparam int REQ_PC = 1;
    localparam int REQ_RF = 2;

    localparam int N_REQ_DEFAULT = 3;

endpackage

// File: rtl/lua_arb_select.sv
// rtl/lua_arb_select.sv - one-hot winner select; LUA_ARB_ROUND_ROBIN_EN picks round-robin over fixed priority.
module lua_arb_select
    import lua_cpu_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] active_i,
`ifdef LUA_ARB_ROUND_ROBIN_EN
    input  logic [IDX_W-1:0] ptr_i,
`endif
    output logic [N_REQ-1:0] winner_o,
    output logic [IDX_W-1:0] winner_idx_o
);

`ifdef LUA_ARB_ROUND_ROBIN_EN
    int j;

    // Walk the ring backwards so the candidate nearest the pointer is assigned last and wins.
    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        j            = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (active_i[j]) begin
                winner_o     = '0;
                winner_o[j]  = 1'b1;
                winner_idx_o = IDX_W'(j);
            end
        end
    end
`else
    always_comb begin
        winner_o     = '0;
        winner_idx_o = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (active_i[i]) begin
                winner_o     = '0;
                winner_o[i]  = 1'b1;
                winner_idx_o = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/lua_mem_arbiter.sv
// rtl/lua_mem_arbiter.sv - serializing Avalon-MM arbiter for lua_cpu; LUA_ARB_ROUND_ROBIN_EN enables round-robin.
module lua_mem_arbiter
    import lua_cpu_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEFAULT,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ*ADDR_W-1:0]   req_address,
    input  logic [N_REQ*DATA_W-1:0]   req_writedata,
    input  logic [N_REQ-1:0]          req_read,
    input  logic [N_REQ-1:0]          req_write,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [N_REQ-1:0]          req_waitrequest,
    output logic [N_REQ-1:0]          grant,
    output logic                      busy,
    output logic [ADDR_W-1:0]         m_address,
    output logic [DATA_W-1:0]         m_writedata,
    output logic                      m_read,
    output logic                      m_write,
    input  logic [DATA_W-1:0]         m_readdata,
    input  logic                      m_waitrequest
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [0:0]       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] active;
    logic [N_REQ-1:0] sel_onehot;
    logic [IDX_W-1:0] sel_idx;
    logic             g_read, g_write, complete;

    assign active = req_read | req_write;

`ifdef LUA_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    lua_arb_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_select (
        .active_i     (active),
        .ptr_i        (ptr_q),
        .winner_o     (sel_onehot),
        .winner_idx_o (sel_idx)
    );

    // Next search starts just past the requester that actually completed.
    always_comb begin
        ptr_d = ptr_q;
        if (complete) begin
            ptr_d = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`else
    lua_arb_select #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_select (
        .active_i     (active),
        .winner_o     (sel_onehot),
        .winner_idx_o (sel_idx)
    );
`endif

    assign busy     = (state_q == ARB_GRANT);
    assign grant    = grant_q;
    assign g_read   = busy & req_read[idx_q];
    assign g_write  = busy & req_write[idx_q];

    // Write takes precedence when a requester raises both strobes.
    assign m_write     = g_write;
    assign m_read      = g_read & ~g_write;
    assign m_address   = busy ? req_address[int'(idx_q)*ADDR_W +: ADDR_W]   : '0;
    assign m_writedata = busy ? req_writedata[int'(idx_q)*DATA_W +: DATA_W] : '0;
    assign complete    = (m_read | m_write) & ~m_waitrequest;

    assign req_readdata    = m_readdata;
    assign req_waitrequest = ~(grant_q & {N_REQ{~m_waitrequest}});

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        if (state_q == ARB_IDLE) begin
            if (|active) begin
                state_d = ARB_GRANT;
                grant_d = sel_onehot;
                idx_d   = sel_idx;
            end
        end else if (complete || !(g_read || g_write)) begin
            state_d = ARB_IDLE;
            grant_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
        end
    end

endmodule
